// File: rtl/disp_rdarb.sv
// rtl/disp_rdarb.sv - two-requester AXI read-channel burst arbiter; option macro DISP_RDARB_FIXPRIO_EN gives requester 0 fixed priority
module disp_rdarb #(
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_M_AXI_ADDR_WIDTH      = 32
) (
   input  logic                               ACLK,
   input  logic                               ARST,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      R0_ARADDR,
   input  logic [7:0]                         R0_ARLEN,
   input  logic                               R0_ARVALID,
   output logic                               R0_ARREADY,
   output logic                               R0_RVALID,
   output logic                               R0_RLAST,
   input  logic                               R0_RREADY,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      R1_ARADDR,
   input  logic [7:0]                         R1_ARLEN,
   input  logic                               R1_ARVALID,
   output logic                               R1_ARREADY,
   output logic                               R1_RVALID,
   output logic                               R1_RLAST,
   input  logic                               R1_RREADY,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
   output logic [7:0]                         M_AXI_ARLEN,
   output logic                               M_AXI_ARVALID,
   input  logic                               M_AXI_ARREADY,
   input  logic                               M_AXI_RVALID,
   input  logic                               M_AXI_RLAST,
   output logic                               M_AXI_RREADY,
   output logic [1:0]                         GRANT,
   output logic                               LEN_ERR,
   input  logic                               LEN_ERR_CLR
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t                               state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]        araddr_q, araddr_d;
   logic [7:0]                           arlen_q, arlen_d;
   logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   arid_q, arid_d;
   logic [1:0]                           grant_q, grant_d;
   logic [8:0]                           beat_cnt_q, beat_cnt_d;
   logic                                 len_err_q, len_err_d;

   logic       any_req;
   logic       win;          // 1 selects requester 1
   logic       sel_rready;
   logic       beat;
   logic       len_set;
   logic [8:0] beat_next;
   logic [8:0] burst_beats;

   assign any_req = R0_ARVALID | R1_ARVALID;

`ifdef DISP_RDARB_FIXPRIO_EN
   // display fetch takes every tie; the secondary reader only gets the port when the display is quiet
   always_comb win = ~R0_ARVALID;
`else
   logic last_win_q, last_win_d;

   // round-robin: on a tie the requester not served last goes next; a lone requester always wins
   always_comb begin
      if (R0_ARVALID && R1_ARVALID) begin
         win = ~last_win_q;
      end else begin
         win = R1_ARVALID;
      end
   end

   assign last_win_d = (state_q == ST_IDLE && any_req) ? win : last_win_q;

   // last-winner register starts at 1 so the display wins the very first tie
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         last_win_q <= 1'b1;
      end else begin
         last_win_q <= last_win_d;
      end
   end
`endif

   assign M_AXI_ARVALID = (state_q == ST_ADDR);
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARLEN   = arlen_q;
   assign M_AXI_ARID    = arid_q;
   assign GRANT         = grant_q;
   assign LEN_ERR       = len_err_q;

   // next-state, request acceptance, read-data steering and burst-length checking
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arid_d      = arid_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      len_err_d   = len_err_q;
      R0_ARREADY  = 1'b0;
      R1_ARREADY  = 1'b0;
      R0_RVALID   = 1'b0;
      R0_RLAST    = 1'b0;
      R1_RVALID   = 1'b0;
      R1_RLAST    = 1'b0;
      M_AXI_RREADY = 1'b0;
      len_set     = 1'b0;
      beat        = 1'b0;
      sel_rready  = grant_q[1] ? R1_RREADY : R0_RREADY;
      beat_next   = beat_cnt_q + 9'd1;
      burst_beats = {1'b0, arlen_q} + 9'd1;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               R0_ARREADY = ~win;
               R1_ARREADY = win;
               araddr_d   = win ? R1_ARADDR : R0_ARADDR;
               arlen_d    = win ? R1_ARLEN : R0_ARLEN;
               arid_d     = '0;
               arid_d[0]  = win;
               grant_d    = win ? 2'b10 : 2'b01;
               beat_cnt_d = '0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            M_AXI_RREADY = sel_rready;
            R0_RVALID    = grant_q[0] & M_AXI_RVALID;
            R0_RLAST     = grant_q[0] & M_AXI_RLAST;
            R1_RVALID    = grant_q[1] & M_AXI_RVALID;
            R1_RLAST     = grant_q[1] & M_AXI_RLAST;
            beat         = M_AXI_RVALID & sel_rready;
            if (beat) begin
               beat_cnt_d = beat_next;
               if (M_AXI_RLAST) begin
                  // early or late RLAST both count as a mismatch
                  len_set = (beat_next != burst_beats);
                  state_d = ST_IDLE;
                  grant_d = 2'b00;
               end else begin
                  // expected final beat arrived without RLAST; keep waiting for it
                  len_set = (beat_next == burst_beats);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase

      // a new mismatch beats a coincident clear
      if (LEN_ERR_CLR) begin
         len_err_d = 1'b0;
      end
      if (len_set) begin
         len_err_d = 1'b1;
      end
   end

   // state and latched-request registers
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state_q    <= ST_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arid_q     <= '0;
         grant_q    <= 2'b00;
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arid_q     <= arid_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end

endmodule

// File: tb/tb_disp_rdarb.sv
// tb/tb_disp_rdarb.sv - randomized self-checking bench for disp_rdarb
module tb_disp_rdarb;

   logic        clk = 1'b0;
   logic        arst;
   logic [31:0] r0_araddr, r1_araddr;
   logic [7:0]  r0_arlen, r1_arlen;
   logic        r0_arvalid, r1_arvalid;
   logic        r0_arready, r1_arready;
   logic        r0_rvalid, r1_rvalid, r0_rlast, r1_rlast;
   logic        r0_rready, r1_rready;
   logic [0:0]  m_arid;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic [1:0]  grant;
   logic        len_err, len_err_clr;

   int total = 0;
   int bad   = 0;

   // reference state: who was served last, and the sticky error flag
   int last_m = 1;
   bit err_m  = 1'b0;

   always #5 clk = ~clk;

   disp_rdarb #(
      .C_M_AXI_THREAD_ID_WIDTH(1),
      .C_M_AXI_ADDR_WIDTH(32)
   ) dut (
      .ACLK(clk), .ARST(arst),
      .R0_ARADDR(r0_araddr), .R0_ARLEN(r0_arlen), .R0_ARVALID(r0_arvalid), .R0_ARREADY(r0_arready),
      .R0_RVALID(r0_rvalid), .R0_RLAST(r0_rlast), .R0_RREADY(r0_rready),
      .R1_ARADDR(r1_araddr), .R1_ARLEN(r1_arlen), .R1_ARVALID(r1_arvalid), .R1_ARREADY(r1_arready),
      .R1_RVALID(r1_rvalid), .R1_RLAST(r1_rlast), .R1_RREADY(r1_rready),
      .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen), .M_AXI_ARVALID(m_arvalid),
      .M_AXI_ARREADY(m_arready), .M_AXI_RVALID(m_rvalid), .M_AXI_RLAST(m_rlast), .M_AXI_RREADY(m_rready),
      .GRANT(grant), .LEN_ERR(len_err), .LEN_ERR_CLR(len_err_clr)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input bit v0, input bit v1);
`ifdef DISP_RDARB_FIXPRIO_EN
      return v0 ? 0 : 1;
`else
      if (v0 && v1) return (last_m == 0) ? 1 : 0;
      return v0 ? 0 : 1;
`endif
   endfunction

   task automatic do_burst(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [7:0] l0, input logic [7:0] l1, input int nbeats, input int ar_delay,
                           input int rdy_mode, input bit clr_last, input int abort_at, output int w);
      int k, cyc_cnt, arv_cnt, seen;
      logic [31:0] ea;
      logic [7:0]  el;
      logic [1:0]  eg;
      logic [3:0]  obs, expv;
      bit rv, rr, last_beat, hs, mism;
      r0_araddr = a0; r1_araddr = a1; r0_arlen = l0; r1_arlen = l1;
      r0_arvalid = v0; r1_arvalid = v1;
      w  = model_pick(v0, v1);
      ea = (w == 1) ? a1 : a0;
      el = (w == 1) ? l1 : l0;
      eg = (w == 1) ? 2'b10 : 2'b01;
      mism = (nbeats != int'(el) + 1);
      #1;
      total++;
      if ({r1_arready, r0_arready} !== eg) begin
         bad++;
         $display("FAIL arready_select: got %b want %b", {r1_arready, r0_arready}, eg);
      end
      step;
      if (w == 0) r0_arvalid = 1'b0; else r1_arvalid = 1'b0;
      last_m = w;
      arv_cnt = 0;
      for (int d = 0; d <= ar_delay; d++) begin
         m_arready = (d == ar_delay);
         #1;
         total++;
         if (m_arvalid !== 1'b1 || m_araddr !== ea || m_arlen !== el || m_arid !== w[0] || grant !== eg
             || r0_arready !== 1'b0 || r1_arready !== 1'b0) begin
            bad++;
            $display("FAIL addr_phase: got v=%b a=%h l=%h id=%b g=%b want v=1 a=%h l=%h id=%b g=%b",
                     m_arvalid, m_araddr, m_arlen, m_arid, grant, ea, el, w[0], eg);
         end
         if (m_arvalid === 1'b1) arv_cnt++;
         step;
      end
      m_arready = 1'b0;
      total++;
      if (arv_cnt !== ar_delay + 1) begin
         bad++;
         $display("FAIL arvalid_cycles: got %0d want %0d", arv_cnt, ar_delay + 1);
      end
      k = 0; cyc_cnt = 0; seen = 0;
      while (k < nbeats) begin
         rv = ($urandom_range(0, 3) != 0);
         if (k == abort_at) rv = 1'b1;
         case (rdy_mode)
            0: rr = 1'($urandom_range(0, 1));
            1: rr = cyc_cnt[0];
            default: rr = 1'b1;
         endcase
         last_beat = rv && (k == nbeats - 1);
         m_rvalid = rv; m_rlast = last_beat;
         if (w == 0) begin r0_rready = rr; r1_rready = 1'($urandom_range(0, 1)); end
         else        begin r1_rready = rr; r0_rready = 1'($urandom_range(0, 1)); end
         hs = rv && rr;
         len_err_clr = clr_last && last_beat && hs;
         arst = (k == abort_at);
         #1;
         if (w == 0) obs = {r0_rvalid, r0_rlast, r1_rvalid, r1_rlast};
         else        obs = {r1_rvalid, r1_rlast, r0_rvalid, r0_rlast};
         expv = {rv, last_beat, 2'b00};
         total++;
         if (obs !== expv || m_rready !== rr || grant !== eg || m_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL r_path: got rv/rl/orv/orl=%b rready=%b g=%b arv=%b want %b rready=%b g=%b arv=0",
                     obs, m_rready, grant, m_arvalid, expv, rr, eg);
         end
         if (obs[3] === 1'b1 && rr) seen++;
         if (arst) begin
            step;
            arst = 1'b0; r0_arvalid = 1'b0; r1_arvalid = 1'b0; len_err_clr = 1'b0;
            last_m = 1; err_m = 1'b0;
            #1;
            total++;
            if (grant !== 2'b00 || m_arvalid !== 1'b0 || m_rready !== 1'b0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0
                || r0_rlast !== 1'b0 || r1_rlast !== 1'b0 || m_araddr !== 32'h0 || m_arlen !== 8'h0
                || m_arid !== 1'b0 || len_err !== 1'b0 || r0_arready !== 1'b0 || r1_arready !== 1'b0) begin
               bad++;
               $display("FAIL arst_mid_burst: got g=%b arv=%b rr=%b rv=%b%b a=%h l=%h err=%b want all zero",
                        grant, m_arvalid, m_rready, r0_rvalid, r1_rvalid, m_araddr, m_arlen, len_err);
            end
            m_rvalid = 1'b0; m_rlast = 1'b0;
            return;
         end
         step;
         if (hs) k++;
         cyc_cnt++;
         if (cyc_cnt > 500) begin
            total++; bad++;
            $display("FAIL data_timeout: got %0d beats want %0d", k, nbeats);
            m_rvalid = 1'b0; m_rlast = 1'b0; len_err_clr = 1'b0;
            arst = 1'b1; step; arst = 1'b0; last_m = 1; err_m = 1'b0;
            return;
         end
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; len_err_clr = 1'b0; r0_rready = 1'b0; r1_rready = 1'b0;
      if (clr_last) err_m = mism; else err_m = err_m | mism;
      #1;
      total++;
      if (grant !== 2'b00 || len_err !== err_m || seen !== nbeats) begin
         bad++;
         $display("FAIL burst_end: got g=%b err=%b beats=%0d want g=00 err=%b beats=%0d",
                  grant, len_err, seen, err_m, nbeats);
      end
   endtask

   task automatic test_reset;
      arst = 1'b1; r0_arvalid = 0; r1_arvalid = 0; r0_araddr = 0; r1_araddr = 0; r0_arlen = 0; r1_arlen = 0;
      r0_rready = 0; r1_rready = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; len_err_clr = 0;
      step; step;
      arst = 1'b0;
      #1;
      total++;
      if (grant !== 2'b00 || m_arvalid !== 1'b0 || m_rready !== 1'b0 || r0_arready !== 1'b0 || r1_arready !== 1'b0
          || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || r0_rlast !== 1'b0 || r1_rlast !== 1'b0
          || m_araddr !== 32'h0 || m_arlen !== 8'h0 || m_arid !== 1'b0 || len_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got g=%b arv=%b rr=%b a=%h l=%h id=%b err=%b want all zero",
                  grant, m_arvalid, m_rready, m_araddr, m_arlen, m_arid, len_err);
      end
   endtask

   task automatic test_single_r0;
      int w;
      do_burst(1'b1, 1'b0, 32'h2000_0000, 32'h0, 8'h0F, 8'h00, 16, 2, 2, 1'b0, -1, w);
   endtask

   task automatic test_round_robin;
      int w, prev;
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         do_burst(1'b1, 1'b1, 32'h1000_0000 + 32'(i * 64), 32'h3000_0000 + 32'(i * 64), 8'd3, 8'd3, 4,
                  i % 2, 0, 1'b0, -1, w);
`ifdef DISP_RDARB_FIXPRIO_EN
         total++;
         if (w != 0) begin bad++; $display("FAIL fixprio_grant: got %0d want 0", w); end
`else
         if (prev >= 0) begin
            total++;
            if (w == prev) begin bad++; $display("FAIL rr_alternate: got %0d want %0d", w, 1 - prev); end
         end
`endif
         prev = w;
      end
      r0_arvalid = 1'b0; r1_arvalid = 1'b0;
   endtask

   task automatic test_toggle_rready;
      int w;
      do_burst(1'b0, 1'b1, 32'h0, 32'h4000_1000, 8'h00, 8'd7, 8, 1, 1, 1'b0, -1, w);
   endtask

   task automatic test_short_rlast;
      int w;
      do_burst(1'b1, 1'b0, 32'h5000_0000, 32'h0, 8'd7, 8'h00, 4, 0, 2, 1'b0, -1, w);
   endtask

   task automatic test_len_err_clr;
      r0_arvalid = 1'b0; r1_arvalid = 1'b0;
      len_err_clr = 1'b1;
      step;
      len_err_clr = 1'b0;
      err_m = 1'b0;
      #1;
      total++;
      if (len_err !== err_m) begin bad++; $display("FAIL len_err_clr: got %b want %b", len_err, err_m); end
   endtask

   task automatic test_clr_coincident;
      int w;
      do_burst(1'b1, 1'b0, 32'h6000_0000, 32'h0, 8'd7, 8'h00, 5, 1, 2, 1'b1, -1, w);
   endtask

   task automatic test_arst_mid_burst;
      int w;
      do_burst(1'b1, 1'b0, 32'h7000_0000, 32'h0, 8'd7, 8'h00, 8, 0, 2, 1'b0, 2, w);
      do_burst(1'b1, 1'b0, 32'h7000_0100, 32'h0, 8'd3, 8'h00, 4, 1, 0, 1'b0, -1, w);
   endtask

   task automatic test_random;
      bit p0, p1;
      logic [31:0] ra0, ra1;
      logic [7:0] rl0, rl1;
      int w, pw, wl, nb;
      p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rl0 = 0; rl1 = 0;
      for (int i = 0; i < 24; i++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; ra0 = $urandom; rl0 = 8'($urandom_range(0, 15)); end
         if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; ra1 = $urandom; rl1 = 8'($urandom_range(0, 15)); end
         if (!p0 && !p1) begin p0 = 1; ra0 = $urandom; rl0 = 8'($urandom_range(0, 15)); end
         pw = model_pick(p0, p1);
         wl = (pw == 1) ? int'(rl1) : int'(rl0);
         nb = ($urandom_range(0, 4) != 0) ? wl + 1 : int'($urandom_range(1, wl + 2));
         do_burst(p0, p1, ra0, ra1, rl0, rl1, nb, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), -1, w);
         if (w == 0) p0 = 0; else p1 = 0;
      end
      r0_arvalid = 1'b0; r1_arvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_r0();
      test_round_robin();
      test_toggle_rready();
      test_short_rlast();
      test_len_err_clr();
      test_clr_coincident();
      test_len_err_clr();
      test_arst_mid_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/disp_rdarb.md
# disp_rdarb

AXI read-channel arbiter sharing the display's single AXI master read port between two burst requesters: requester 0, the display VRAM fetch, and requester 1, a secondary reader such as a cursor or overlay fetch. It sits between the requesters and the M_AXI_AR*/R* ports. It grants one burst at a time, forwards the address, steers read-data handshakes to the granted requester, and checks burst length against RLAST.

## Interface
- C_M_AXI_THREAD_ID_WIDTH, 1, width of ARID/RID
- C_M_AXI_ADDR_WIDTH, 32, address width
- ACLK  in  1  clock; all logic on rising edge
- ARST  in  1  reset, synchronous, active-high
- R0_ARADDR / R1_ARADDR  in  C_M_AXI_ADDR_WIDTH  requester burst start address
- R0_ARLEN / R1_ARLEN  in  8  requester burst length minus 1
- R0_ARVALID / R1_ARVALID  in  1  request valid; held until accepted
- R0_ARREADY / R1_ARREADY  out  1  request accepted this cycle
- R0_RVALID / R1_RVALID  out  1  data beat valid for this requester
- R0_RLAST / R1_RLAST  out  1  last beat for this requester
- R0_RREADY / R1_RREADY  in  1  requester accepts beat
- M_AXI_ARID  out  C_M_AXI_THREAD_ID_WIDTH  granted requester index, zero-extended
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  latched address
- M_AXI_ARLEN  out  8  latched length
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  slave accepts address
- M_AXI_RVALID, M_AXI_RLAST  in  1  slave data beat and last flag; RDATA wired directly to both requesters outside this block
- M_AXI_RREADY  out  1  forwarded RREADY of the granted requester
- GRANT  out  2  one-hot current owner; 00 when idle
- LEN_ERR  out  1  sticky burst-length mismatch flag
- LEN_ERR_CLR  in  1  clears LEN_ERR

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - If any Rn_ARVALID is high, select winner g.
  - Assert Rg_ARREADY combinationally for that cycle only.
  - Latch ARADDR and ARLEN, set ARID=g, set GRANT one-hot, reset the beat counter, go to ADDR.
- ADDR
  - M_AXI_ARVALID=1 and the address is held stable.
  - On M_AXI_ARREADY, go to DATA.
- DATA
  - Rg_RVALID=M_AXI_RVALID, Rg_RLAST=M_AXI_RLAST, M_AXI_RREADY=Rg_RREADY.
  - The non-granted requester sees RVALID=0 and RLAST=0.
  - Each beat (RVALID&RREADY) increments an 9-bit beat counter.
  - On the beat with RLAST: if count+1 ≠ ARLEN+1, set LEN_ERR. Then go to IDLE and clear GRANT.
  - A beat with count+1 = ARLEN+1 but no RLAST also sets LEN_ERR. The FSM still waits for RLAST.
- Only one burst is outstanding; M_AXI_RID is ignored.
- Winner selection default is round-robin via a last-winner register (reset value 1, so requester 0 wins first). On a tie, the requester not last served wins. A lone requester always wins.
- If LEN_ERR_CLR and a set condition occur in the same cycle, set wins.

## Timing
- Reset values:
  - state IDLE, GRANT=00
  - all Rn_ARREADY, Rn_RVALID, Rn_RLAST = 0
  - M_AXI_ARVALID=0, M_AXI_RREADY=0
  - ARADDR, ARLEN, ARID = 0
  - LEN_ERR=0, last-winner=1
- Latency:
  - Rn_ARVALID sampled in IDLE at cycle n gives M_AXI_ARVALID high at n+1.
  - Minimum three cycles per burst of overhead: IDLE, ADDR, then data beats.
  - The first request after burst end can be accepted in the cycle after RLAST.
- R path is combinational pass-through with zero added latency.
- M_AXI_ARVALID never drops before ARREADY. ARADDR and ARLEN do not change while ARVALID is high.
- ARST asserted mid-burst: the FSM returns to IDLE next edge and outstanding beats are dropped. The system resets the slave with the same reset.
- ARREADY already high in the first ADDR cycle: handshake completes in that cycle.

## Configuration
- DISP_RDARB_FIXPRIO_EN defined:
  - Requester 0 (display) always wins a tie; last-winner is unused.
  - Requester 1 is served only when R0_ARVALID is low in IDLE.
- Undefined: round-robin as described in Operation.

## Test plan
- Single R0 request, ADDR=0x2000_0000, LEN=0x0F, slave ARREADY after 2 cycles, 16 beats with RLAST on beat 16 -> ARVALID high for 3 cycles, R0 receives 16 beats, LEN_ERR=0, GRANT 01 then 00.
- R0 and R1 both valid continuously, each LEN=3 -> grants alternate 01,10,01,10 in round-robin. With DISP_RDARB_FIXPRIO_EN, every grant is 01.
- R1 burst LEN=7, requester RREADY toggles every other cycle -> M_AXI_RREADY mirrors R1_RREADY, R0_RVALID stays 0, 8 beats counted.
- Slave asserts RLAST on beat 4 of LEN=7 -> LEN_ERR=1, FSM returns to IDLE. LEN_ERR_CLR pulse clears it.
- ARST pulse during DATA beat 3 -> next cycle GRANT=00, all outputs at reset values, new R0 request accepted normally.
- LEN_ERR_CLR coincident with a mismatching RLAST -> LEN_ERR remains 1.
